pin_lock: RTL and testbench
===========================

# pin_lock

Parametrised PIN-entry lock FSM, the generalised successor to the fixed 4-digit safe. It accepts a stream of `DIGIT_W`-bit digits, compares a `PIN_LEN`-digit entry against a stored PIN and asserts `unlocked` on a match. It adds a failed-attempt counter with a timed lockout and an optional in-field PIN change. There is no hidden alternate code path. It sits behind the keypad/digit front end and drives the downstream unlock enable.

## Interface
Parameters:
- `DIGIT_W`, 4 — bits per digit.
- `PIN_LEN`, 4 — digits per PIN, ≥1.
- `RESET_PIN`, `16'hC0DE` — PIN after reset, `PIN_LEN*DIGIT_W` bits, first digit in the MSBs.
- `MAX_FAILS`, 3 — consecutive failed entries that trigger lockout, ≥1.
- `LOCKOUT_CYCLES`, 16 — lockout duration in clocks, ≥1.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `din` in `DIGIT_W` — digit value.
- `din_valid` in 1 — digit strobe; one digit is consumed per cycle while high.
- `lock` in 1 — relock request.
- `prog` in 1 — marks digits as new-PIN digits (see Configuration).
- `unlocked` out 1 — high in the UNLOCKED state.
- `locked_out` out 1 — high in the LOCKOUT state.
- `fail_count` out `$clog2(MAX_FAILS+1)` — consecutive failures so far.

## Operation
- States: ENTRY, UNLOCKED, LOCKOUT, plus PROGRAM when the feature is enabled.
- Reset: state ENTRY, digit index 0, mismatch flag 0, `fail_count` 0, PIN register ← `RESET_PIN`.
  - Outputs after reset: `unlocked` 0, `locked_out` 0.
  - Reset mid-entry, mid-lockout or mid-program aborts that operation with no residue.
- ENTRY:
  - Each `din_valid` digit is compared against PIN digit `idx` (MSB-first) and ORs any mismatch into the flag.
  - There is no early abort on a wrong digit. All `PIN_LEN` digits are always consumed, so no per-digit information leaks.
  - On the last digit, with the flag and the current digit both taken into account:
    - Match: go to UNLOCKED; `fail_count` ← 0.
    - Mismatch with `fail_count+1 < MAX_FAILS`: stay in ENTRY; `fail_count` +1.
    - Mismatch with `fail_count+1 == MAX_FAILS`: go to LOCKOUT; `fail_count` saturates at `MAX_FAILS`.
  - Index and flag clear after every complete entry.
- LOCKOUT:
  - `din_valid`, `lock` and `prog` are ignored.
  - The timer runs `LOCKOUT_CYCLES` cycles, then the state returns to ENTRY with `fail_count` ← 0.
- UNLOCKED:
  - `lock` = 1: go to ENTRY next cycle. `lock` takes priority over a simultaneous `din_valid`.
  - `din_valid` with `prog` = 0: ignored.
- `lock` in ENTRY clears a partial entry (index and flag ← 0) without counting a failure.
- Digit index wraps 0..`PIN_LEN`-1.

## Timing
- `unlocked` rises on the clock edge after the edge that samples the final correct digit.
- `locked_out` rises on the edge after the failing final digit and is high for exactly `LOCKOUT_CYCLES` cycles.
- The first digit accepted again is the one sampled on the cycle after `locked_out` falls.
- `unlocked` falls on the edge after `lock` is sampled.
- All outputs are registered or decoded directly from the state register; there are no input-to-output combinational paths.
- `din_valid` may be high every cycle (back-to-back digits).

## Configuration
- Macro `PIN_LOCK_PROGRAM_EN`.
- Defined:
  - In UNLOCKED, `din_valid && prog` enters PROGRAM and captures that digit as new digit 0.
  - PROGRAM accepts `PIN_LEN` digits total into a shadow register, then commits shadow → PIN and returns to UNLOCKED.
  - `lock` during PROGRAM discards the shadow, leaves the PIN unchanged and goes to ENTRY.
  - `unlocked` stays high during PROGRAM.
- Undefined: the `prog` port exists but is ignored, PROGRAM and the shadow register are not built, and the PIN is constant `RESET_PIN`.

## Structure
- `pin_lock_pkg`: `pin_lock_state_t` enum (ENTRY, UNLOCKED, LOCKOUT, PROGRAM) and a digit-index width helper function.
- Sub-module `pin_lock_timer`:
  - Loadable down-counter of width `$clog2(LOCKOUT_CYCLES+1)`.
  - Ports: `start` and `busy`.
  - Instantiated once for LOCKOUT timing.

## Test plan
- Default params, digits c,0,d,e → `unlocked` = 1 one cycle after `e`, `fail_count` = 0.
- Legacy secret f,0,0,f → no unlock, `fail_count` = 1. Three wrong entries → `locked_out` high exactly 16 cycles, digits during lockout ignored, then c,0,d,e unlocks.
- Wrong first digit 1,0,d,e → stays in ENTRY until the 4th digit, then `fail_count` = 1, no unlock.
- Unlocked with `lock` and `din_valid` in the same cycle → `unlocked` = 0 next cycle, digit not consumed.
- With `PIN_LOCK_PROGRAM_EN`: unlock, program 1,2,3,4 with `prog`, lock → c,0,d,e fails and 1,2,3,4 unlocks. Reset → c,0,d,e unlocks again.
- Reset asserted on the 3rd lockout cycle and during a partial entry → next cycle all outputs 0, then a full correct PIN unlocks.

Source files
------------

// File: rtl/pin_lock_pkg.sv
// Shared types and helpers for the pin_lock block.
package pin_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY    = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2,
    PROGRAM  = 2'd3
  } pin_lock_state_t;

  // Width of a digit index; a one-digit PIN still needs one index bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pin_lock_timer.sv
// Loadable lockout down-counter: start loads it, busy is high while it counts.
module pin_lock_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Loaded with CYCLES-1 so the owner sees busy drop after exactly CYCLES cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (start) begin
      r_cnt <= CNT_W'(CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/pin_lock.sv
// PIN-entry lock with failed-attempt lockout.
// Define PIN_LOCK_PROGRAM_EN to build in-field PIN change (PROGRAM state).
module pin_lock
  import pin_lock_pkg::*;
#(
  parameter int unsigned                 DIGIT_W        = 4,
  parameter int unsigned                 PIN_LEN        = 4,
  parameter logic [PIN_LEN*DIGIT_W-1:0]  RESET_PIN      = 16'hC0DE,
  parameter int unsigned                 MAX_FAILS      = 3,
  parameter int unsigned                 LOCKOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DIGIT_W-1:0]                 din,
  input  logic                               din_valid,
  input  logic                               lock,
  input  logic                               prog,
  output logic                               unlocked,
  output logic                               locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);

  localparam int unsigned PIN_W  = PIN_LEN * DIGIT_W;
  localparam int unsigned IDX_W  = idx_w(PIN_LEN);
  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);

  pin_lock_state_t   r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_flag;
  logic [FAIL_W-1:0] r_fail_count;
  logic              r_unlocked;
  logic              r_locked_out;

  logic [PIN_W-1:0]   w_pin;
  logic [DIGIT_W-1:0] w_pin_digit;
  logic               w_last;
  logic               w_entry_bad;
  logic               w_fail_limit;
  logic               w_start;
  logic               w_busy;

`ifdef PIN_LOCK_PROGRAM_EN
  logic [PIN_W-1:0] r_pin;
  logic [PIN_W-1:0] r_shadow;
  logic [PIN_W-1:0] w_shadow_next;

  assign w_pin = r_pin;

  // Shadow with the incoming digit dropped into slot r_idx (MSB-first).
  always_comb begin
    w_shadow_next = r_shadow;
    for (int unsigned i = 0; i < PIN_LEN; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_shadow_next[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W] = din;
      end
    end
  end
`else
  logic w_prog_unused;

  assign w_pin         = RESET_PIN;
  assign w_prog_unused = prog;
`endif

  // Expected digit for the current index, MSB-first.
  always_comb begin
    w_pin_digit = '0;
    for (int unsigned i = 0; i < PIN_LEN; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_pin_digit = w_pin[(PIN_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  assign w_last       = (r_idx == IDX_W'(PIN_LEN - 1));
  assign w_entry_bad  = r_flag | (din != w_pin_digit);
  assign w_fail_limit = (32'(r_fail_count) + 32'd1) >= MAX_FAILS;
  assign w_start      = (r_state == ENTRY) && din_valid && !lock &&
                        w_last && w_entry_bad && w_fail_limit;

  pin_lock_timer #(
    .CYCLES (LOCKOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .busy  (w_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ENTRY;
      r_idx        <= '0;
      r_flag       <= 1'b0;
      r_fail_count <= '0;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
`ifdef PIN_LOCK_PROGRAM_EN
      r_pin        <= RESET_PIN;
      r_shadow     <= '0;
`endif
    end else begin
      case (r_state)
        ENTRY: begin
          if (lock) begin
            r_idx  <= '0;
            r_flag <= 1'b0;
          end else if (din_valid) begin
            if (w_last) begin
              r_idx  <= '0;
              r_flag <= 1'b0;
              if (!w_entry_bad) begin
                r_state      <= UNLOCKED;
                r_unlocked   <= 1'b1;
                r_fail_count <= '0;
              end else if (w_fail_limit) begin
                r_state      <= LOCKOUT;
                r_locked_out <= 1'b1;
                r_fail_count <= FAIL_W'(MAX_FAILS);
              end else begin
                r_fail_count <= r_fail_count + FAIL_W'(1);
              end
            end else begin
              r_idx  <= r_idx + IDX_W'(1);
              r_flag <= w_entry_bad;
            end
          end
        end
        LOCKOUT: begin
          if (!w_busy) begin
            r_state      <= ENTRY;
            r_locked_out <= 1'b0;
            r_fail_count <= '0;
          end
        end
        UNLOCKED: begin
          if (lock) begin
            r_state    <= ENTRY;
            r_unlocked <= 1'b0;
            r_idx      <= '0;
            r_flag     <= 1'b0;
          end
`ifdef PIN_LOCK_PROGRAM_EN
          else if (din_valid && prog) begin
            if (w_last) begin
              r_pin <= w_shadow_next;
            end else begin
              r_state  <= PROGRAM;
              r_shadow <= w_shadow_next;
              r_idx    <= r_idx + IDX_W'(1);
            end
          end
`endif
        end
`ifdef PIN_LOCK_PROGRAM_EN
        PROGRAM: begin
          if (lock) begin
            r_state    <= ENTRY;
            r_unlocked <= 1'b0;
            r_idx      <= '0;
            r_shadow   <= '0;
          end else if (din_valid) begin
            if (w_last) begin
              r_pin   <= w_shadow_next;
              r_state <= UNLOCKED;
              r_idx   <= '0;
            end else begin
              r_shadow <= w_shadow_next;
              r_idx    <= r_idx + IDX_W'(1);
            end
          end
        end
`endif
        default: begin
          r_state <= ENTRY;
        end
      endcase
    end
  end

  assign unlocked   = r_unlocked;
  assign locked_out = r_locked_out;
  assign fail_count = r_fail_count;

endmodule

// File: tb/tb_pin_lock.sv
// Randomized and directed bench for pin_lock against a digit-queue reference model.
module tb_pin_lock;

  localparam int unsigned DIGIT_W   = 4;
  localparam int unsigned PIN_LEN   = 4;
  localparam logic [15:0] RESET_PIN = 16'hC0DE;
  localparam int unsigned MAX_FAILS = 3;
  localparam int unsigned LOCK_CYC  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       din_valid;
  logic       lock;
  logic       prog;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode as plain integer, entry digits collected in a queue.
  int         m_mode;       // 0 entry, 1 open, 2 lockout, 3 programming
  logic [3:0] m_digits[$];
  int         m_fails;
  int         m_left;
  logic [15:0] m_pin;

  pin_lock #(
    .DIGIT_W        (DIGIT_W),
    .PIN_LEN        (PIN_LEN),
    .RESET_PIN      (RESET_PIN),
    .MAX_FAILS      (MAX_FAILS),
    .LOCKOUT_CYCLES (LOCK_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .lock       (lock),
    .prog       (prog),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] queue_value();
    logic [15:0] v = '0;
    foreach (m_digits[k]) v = {v[11:0], m_digits[k]};
    return v;
  endfunction

  function automatic logic [3:0] pin_digit(input int k);
    logic [15:0] s = m_pin >> (4 * (3 - k));
    return s[3:0];
  endfunction

  task automatic model_step(input logic r, input logic [3:0] d, input logic v,
                            input logic l, input logic p);
    if (r) begin
      m_mode = 0; m_digits.delete(); m_fails = 0; m_left = 0; m_pin = RESET_PIN;
      return;
    end
    case (m_mode)
      0: begin
        if (l) m_digits.delete();
        else if (v) begin
          m_digits.push_back(d);
          if (m_digits.size() == PIN_LEN) begin
            if (queue_value() == m_pin) begin
              m_mode = 1; m_fails = 0;
            end else begin
              m_fails++;
              if (m_fails == MAX_FAILS) begin m_mode = 2; m_left = LOCK_CYC; end
            end
            m_digits.delete();
          end
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_fails = 0; end
      end
      1: begin
        if (l) m_mode = 0;
`ifdef PIN_LOCK_PROGRAM_EN
        else if (v && p) begin
          m_digits.delete();
          m_digits.push_back(d);
          m_mode = 3;
        end
`endif
      end
      3: begin
        if (l) begin m_mode = 0; m_digits.delete(); end
        else if (v) begin
          m_digits.push_back(d);
          if (m_digits.size() == PIN_LEN) begin
            m_pin = queue_value(); m_mode = 1; m_digits.delete();
          end
        end
      end
      default: m_mode = 0;
    endcase
  endtask

  task automatic compare_all();
    chk("unlocked", 32'(unlocked), 32'(m_mode == 1 || m_mode == 3));
    chk("locked_out", 32'(locked_out), 32'(m_mode == 2));
    chk("fail_count", 32'(fail_count), 32'(m_fails));
  endtask

  // One clock: drive inputs, step the model on the edge, compare on the falling edge.
  task automatic cyc(input logic r, input logic [3:0] d, input logic v,
                     input logic l, input logic p);
    reset = r; din = d; din_valid = v; lock = l; prog = p;
    @(posedge clk);
    model_step(r, d, v, l, p);
    @(negedge clk);
    compare_all();
  endtask

  task automatic enter(input logic [15:0] code);
    for (int k = 3; k >= 0; k--) begin
      logic [15:0] s = code >> (4 * k);
      cyc(1'b0, s[3:0], 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int lo_len;
    reset = 1'b1; din = '0; din_valid = 1'b0; lock = 1'b0; prog = 1'b0;
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);

    // Correct PIN opens one cycle after the last digit.
    enter(16'hC0DE);
    chk("plan_unlock", 32'(unlocked), 32'd1);
    chk("plan_unlock_fail", 32'(fail_count), 32'd0);

    // lock with a simultaneous digit: relock wins, digit is dropped.
    cyc(1'b0, 4'hC, 1'b1, 1'b1, 1'b0);
    chk("lock_prio", 32'(unlocked), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'hD, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'hE, 1'b1, 1'b0, 1'b0);
    chk("lock_digit_dropped", 32'(unlocked), 32'd0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("lock_digit_fail", 32'(fail_count), 32'd1);
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);

    // Legacy secret and wrong first digit each count one failure.
    enter(16'hF00F);
    chk("legacy_fail", 32'(fail_count), 32'd1);
    cyc(1'b0, 4'h1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'hD, 1'b1, 1'b0, 1'b0);
    chk("no_early_abort", 32'(fail_count), 32'd1);
    cyc(1'b0, 4'hE, 1'b1, 1'b0, 1'b0);
    chk("wrong_first_fail", 32'(fail_count), 32'd2);
    chk("wrong_first_lock", 32'(unlocked), 32'd0);

    // Third failure locks out for exactly LOCK_CYC cycles while digits are ignored.
    enter(16'h1234);
    chk("lockout_enter", 32'(locked_out), 32'd1);
    chk("lockout_sat", 32'(fail_count), 32'(MAX_FAILS));
    lo_len = 1;
    for (int k = 0; k < 100 && locked_out; k++) begin
      cyc(1'b0, (k % 4 == 0) ? 4'hC : (k % 4 == 1) ? 4'h0 : (k % 4 == 2) ? 4'hD : 4'hE,
          1'b1, 1'b0, 1'b0);
      if (locked_out) lo_len++;
    end
    chk("lockout_len", 32'(lo_len), 32'(LOCK_CYC));
    chk("lockout_exit_fail", 32'(fail_count), 32'd0);
    enter(16'hC0DE);
    chk("post_lockout_unlock", 32'(unlocked), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

`ifdef PIN_LOCK_PROGRAM_EN
    enter(16'hC0DE);
    for (int k = 1; k <= 4; k++) cyc(1'b0, 4'(k), 1'b1, 1'b0, 1'b1);
    chk("prog_still_open", 32'(unlocked), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    enter(16'hC0DE);
    chk("prog_old_rejected", 32'(unlocked), 32'd0);
    enter(16'h1234);
    chk("prog_new_accepted", 32'(unlocked), 32'd1);
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    enter(16'hC0DE);
    chk("prog_reset_restores", 32'(unlocked), 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
`endif

    // Reset on the third lockout cycle and during a partial entry.
    enter(16'h1111); enter(16'h2222); enter(16'h3333);
    idle(2);
    cyc(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_lockout_lo", 32'(locked_out), 32'd0);
    chk("rst_lockout_fail", 32'(fail_count), 32'd0);
    cyc(1'b0, 4'hC, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'hD, 1'b1, 1'b0, 1'b0);
    chk("rst_partial_unl", 32'(unlocked), 32'd0);
    enter(16'hC0DE);
    chk("rst_partial_unlock", 32'(unlocked), 32'd1);

    // Randomized traffic, biased toward correct digits so every state is visited.
    for (int n = 0; n < 4000; n++) begin
      logic       r, v, l, p;
      logic [3:0] d;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 23) == 0);
      p = ($urandom_range(0, 3) == 0);
      if (m_mode == 0 && $urandom_range(0, 2) != 0) d = pin_digit(m_digits.size());
      else d = 4'($urandom_range(0, 15));
      cyc(r, d, v, l, p);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
